// File: rtl/cache_axi_arbiter.sv
// Arbitrates ICache/DCache refill reads and DCache writes onto one AXI3 master port.
// Define ARB_RR_EN for round-robin read selection; otherwise DCache has fixed priority.
module cache_axi_arbiter #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] ICACHE_ID  = 4'd0,
  parameter logic [3:0] DCACHE_ID  = 4'd1
) (
  input  logic                         clk,
  input  logic                         reset,
  // ICache read port
  input  logic                         ic_rd_req,
  input  logic                         ic_rd_type,
  input  logic [31:0]                  ic_rd_addr,
  output logic                         ic_rd_rdy,
  output logic                         ic_ret_valid,
  output logic                         ic_ret_last,
  output logic [31:0]                  ic_ret_data,
  // DCache read port
  input  logic                         dc_rd_req,
  input  logic                         dc_rd_type,
  input  logic [31:0]                  dc_rd_addr,
  output logic                         dc_rd_rdy,
  output logic                         dc_ret_valid,
  output logic                         dc_ret_last,
  output logic [31:0]                  dc_ret_data,
  // DCache write port
  input  logic                         dc_wr_req,
  input  logic                         dc_wr_type,
  input  logic [31:0]                  dc_wr_addr,
  input  logic [3:0]                   dc_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]     dc_wr_data,
  output logic                         dc_wr_rdy,
  // AXI read address / data
  output logic [3:0]                   arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [31:0]                  rdata,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  // AXI write address / data / response
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [31:0]                  wdata,
  output logic [3:0]                   wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic                         bvalid,
  output logic                         bready,
  // FSM state observation
  output logic [1:0]                   dbg_r_state,
  output logic [1:0]                   dbg_w_state
);

  // Handshake rule on every channel: a transfer happens in a cycle where valid
  // and ready are both high at the rising edge; once raised, valid and its
  // payload hold until that cycle. *_rd_rdy / dc_wr_rdy mark request acceptance.

  localparam int              BW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int              OFF       = BW + 2;
  localparam logic [7:0]      LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_state_next;
  w_state_t w_state, w_state_next;

  logic [31:0]   r_addr;
  logic          r_type;
  logic          r_is_dc;

  logic [31:0]   w_addr;
  logic          w_type;
  logic [3:0]    w_strb;
  logic [31:0]   w_words [LINE_WORDS];
  logic [BW-1:0] w_beat;

  logic              hz_valid;
  logic [31:OFF]     hz_line;
  logic              ic_elig, dc_elig;
  logic              grant_dc, grant_ic;
  logic              r_idle_ok;
  logic              rd_beat;

  assign dbg_r_state = r_state;
  assign dbg_w_state = w_state;

  // Hazard line: the buffered write, or the write being accepted this cycle.
  always_comb begin
    hz_valid = 1'b0;
    hz_line  = '0;
    if (w_state != W_IDLE) begin
      hz_valid = 1'b1;
      hz_line  = w_addr[31:OFF];
    end else if (dc_wr_req) begin
      hz_valid = 1'b1;
      hz_line  = dc_wr_addr[31:OFF];
    end
  end

  assign ic_elig = ic_rd_req && !(hz_valid && (ic_rd_addr[31:OFF] == hz_line));
  assign dc_elig = dc_rd_req && !(hz_valid && (dc_rd_addr[31:OFF] == hz_line));

`ifdef ARB_RR_EN
  logic last_grant_dc;

  always_ff @(posedge clk) begin
    if (reset)
      last_grant_dc <= 1'b0;
    else if (ic_rd_rdy || dc_rd_rdy)
      last_grant_dc <= dc_rd_rdy;
  end

  assign grant_dc = dc_elig && (!ic_elig || !last_grant_dc);
`else
  assign grant_dc = dc_elig;
`endif
  assign grant_ic = ic_elig && !grant_dc;

  assign r_idle_ok = (r_state == R_IDLE) && !reset;
  assign ic_rd_rdy = r_idle_ok && grant_ic;
  assign dc_rd_rdy = r_idle_ok && grant_dc;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    unique case (r_state)
      R_IDLE: if (ic_rd_rdy || dc_rd_rdy) r_state_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_type  <= 1'b0;
      r_is_dc <= 1'b0;
    end else if (dc_rd_rdy) begin
      r_addr  <= dc_rd_addr;
      r_type  <= dc_rd_type;
      r_is_dc <= 1'b1;
    end else if (ic_rd_rdy) begin
      r_addr  <= ic_rd_addr;
      r_type  <= ic_rd_type;
      r_is_dc <= 1'b0;
    end
  end

  assign arid   = r_is_dc ? DCACHE_ID : ICACHE_ID;
  assign araddr = r_addr;
  assign arlen  = r_type ? LINE_LEN : 8'd0;
  assign arsize = 3'd2;

  // Return beats are steered by rid straight through to the owning cache.
  assign rd_beat      = rready && rvalid;
  assign ic_ret_valid = rd_beat && (rid == ICACHE_ID);
  assign dc_ret_valid = rd_beat && (rid == DCACHE_ID);
  assign ic_ret_last  = ic_ret_valid && rlast;
  assign dc_ret_last  = dc_ret_valid && rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_data  = rdata;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    dc_wr_rdy    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        dc_wr_rdy = !reset;
        if (dc_wr_req) w_state_next = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_state_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) w_state_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr <= '0;
      w_type <= 1'b0;
      w_strb <= '0;
      w_beat <= '0;
      for (int i = 0; i < LINE_WORDS; i++) w_words[i] <= '0;
    end else begin
      if (dc_wr_rdy && dc_wr_req) begin
        w_addr <= dc_wr_addr;
        w_type <= dc_wr_type;
        w_strb <= dc_wr_type ? 4'hF : dc_wr_wstrb;
        w_beat <= '0;
        for (int i = 0; i < LINE_WORDS; i++) w_words[i] <= dc_wr_data[32*i +: 32];
      end
      if (wvalid && wready) w_beat <= w_beat + 1'b1;
    end
  end

  assign awaddr = w_addr;
  assign awlen  = w_type ? LINE_LEN : 8'd0;
  assign awsize = 3'd2;
  assign wdata  = w_words[w_beat];
  assign wstrb  = w_strb;
  assign wlast  = (w_beat == (w_type ? LAST_BEAT : '0));

  // Channel stability: payload may not change while valid waits for ready.
  a_ar_hold: assert property (@(posedge clk) disable iff (reset)
    (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arlen) && $stable(arid)));
  a_aw_hold: assert property (@(posedge clk) disable iff (reset)
    (awvalid && !awready) |=> (awvalid && $stable(awaddr) && $stable(awlen)));
  a_w_hold: assert property (@(posedge clk) disable iff (reset)
    (wvalid && !wready) |=> (wvalid && $stable(wdata) && $stable(wlast) && $stable(wstrb)));
  a_one_grant: assert property (@(posedge clk) !(ic_rd_rdy && dc_rd_rdy));

endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
- Shares the single AXI3 master port between ICache refill reads, DCache refill/uncached reads and DCache writebacks/uncached writes.
- Sits between the cache pair (fed by the pre-IF/fetch and memory stages) and the SoC AXI interconnect.
- Sequences one read and one write transaction concurrently.
- Enforces read-after-write ordering on the same line.

Parameters:
- LINE_WORDS, 4: words per cache line; burst length for line transfers (16-byte line, 4-bit offset).
- ICACHE_ID, 0: ARID/RID tag for ICache reads.
- DCACHE_ID, 1: ARID/RID tag for DCache reads.

Ports:
- clk  input  1  clock (already decided).
- reset  input  1  synchronous, active-high (already decided).
- ic_rd_req  input  1  ICache read request.
- ic_rd_type  input  1  0 = single word, 1 = line.
- ic_rd_addr  input  32  ICache read address.
- ic_rd_rdy  output  1  ICache request accepted this cycle.
- ic_ret_valid  output  1  ICache return beat valid.
- ic_ret_last  output  1  final ICache beat.
- ic_ret_data  output  32  ICache return data.
- dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data: same meanings and widths as the ICache set, for the DCache.
- dc_wr_req  input  1  DCache write request.
- dc_wr_type  input  1  0 = single word, 1 = line.
- dc_wr_addr  input  32  write address.
- dc_wr_wstrb  input  4  byte strobe, single-word writes only.
- dc_wr_data  input  32*LINE_WORDS  write data; word 0 = bits [31:0].
- dc_wr_rdy  output  1  write accepted this cycle.
- arid 4, araddr 32, arlen 8, arsize 3, arvalid  outputs  AXI read address channel.
- arready  input  1.
- rid 4, rdata 32, rlast 1, rvalid 1  inputs  AXI read data channel.
- rready  output  1.
- awaddr 32, awlen 8, awsize 3, awvalid  outputs  AXI write address channel.
- awready  input  1.
- wdata 32, wstrb 4, wlast 1, wvalid 1  outputs  AXI write data channel.
- wready  input  1.
- bvalid  input  1.
- bready  output  1.
- Not ports, driven as constants: arburst/awburst = INCR, lock/cache/prot = 0, awid = 1.

Behaviour:
- Reset values:
  - Every valid/rdy output and arvalid/awvalid/wvalid = 0; rready = 0; bready = 0.
  - Both FSMs go to IDLE; the write buffer is cleared.
  - Reset mid-burst abandons the transaction with no further AXI handshakes.
- Read FSM states:
  - R_IDLE: selects a requester. Fixed priority: DCache over ICache.
  - Acceptance: the selected requester's *_rd_rdy pulses for 1 cycle. Address, type and ID are latched. Go to R_AR.
  - R_AR: arvalid = 1; araddr = latched address; arsize = 2; arlen = LINE_WORDS-1 for a line, 0 for a single word. On arready, go to R_DATA.
  - R_DATA: rready = 1. Each rvalid beat is routed by rid to the matching ret_valid/ret_data in the same cycle (combinational pass-through). ret_last = rlast. On rlast, return to R_IDLE.
  - No new read is accepted in the rlast cycle.
  - Latency: request to arvalid = 1 cycle; rdata to ret_data = 0 cycles.
- Write FSM states:
  - W_IDLE: dc_wr_rdy = 1. When dc_wr_req is high, latch address, type, data and strobe (line writes use strobe 4'hF). Go to W_AW.
  - W_AW: awvalid = 1; awlen as for reads. On awready, go to W_DATA.
  - W_DATA: wvalid = 1. A 2-bit beat counter selects wdata. wlast is asserted on beat awlen. The counter advances only on wready. After the wlast handshake, go to W_RESP.
  - W_RESP: bready = 1. On bvalid, go to W_IDLE. The buffer stays valid until then.
- Read-after-write hazard:
  - While the write FSM is not in W_IDLE, a read request whose address[31:4] equals the buffered write address[31:4] is not accepted: rdy stays 0 until the cycle after bvalid.
  - Non-matching reads proceed in parallel.
- Simultaneous events:
  - dc_rd_req and dc_wr_req in the same cycle: both are accepted if neither is blocked; the hazard check compares against the newly latched write.
  - Both read requesters at once: DCache wins; ICache is served next time R_IDLE is reached.
- AXI rule: valid signals never drop before their ready handshake; addresses and data are held stable.

Optional Feature:
- ARB_RR_EN defined: read selection is round-robin. A 1-bit last-grant register is updated on each acceptance; on a tie, the requester not granted last wins.
- ARB_RR_EN undefined: fixed DCache-over-ICache priority as described above.

Test Plan:
- ICache line read at 0xBFC00000, arready after 2 cycles, 4 rvalid beats with rid=0 -> arlen=3, araddr=0xBFC00000; ic_ret_valid is high for 4 beats with ic_ret_last on the 4th; dc_ret_valid stays 0.
- ic_rd_req and dc_rd_req in the same cycle -> dc_rd_rdy first with arid=1; ICache is accepted after rlast. With ARB_RR_EN, a second tie grants ICache first.
- DCache line write to 0x00001230 with wready toggling 1,0,1,1,1 -> 4 W beats in word order, wlast on the 4th, bready until bvalid, then dc_wr_rdy=1.
- Write pending at 0x00001230, dc_rd_req to 0x0000123C -> dc_rd_rdy held 0 until the cycle after bvalid. A read to 0x00002000 during the same window is accepted immediately.
- Single-word write, wstrb=4'b0011 -> awlen=0, wstrb=4'b0011, wlast on the 1st beat.
- Reset asserted during R_DATA -> arvalid, rready and ret_valid go to 0 the next cycle; a new request is accepted normally afterwards.
